// File: rtl/load_store_unit.sv
// Load/store initiator for the 64x32 word-wide D-MEM: byte/half/word accesses,
// read-modify-write for sub-word stores, alignment errors answered without touching memory.
module load_store_unit #(
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_write,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_unsigned,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [31:0]       i_req_wdata,
   output logic              o_resp_valid,
   output logic [31:0]       o_resp_rdata,
   output logic              o_resp_error,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_read,
   output logic              o_mem_write,
   output logic [31:0]       o_mem_wdata,
   input  logic [31:0]       i_mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_write;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [1:0]        r_addr_lo;
   logic [31:0]       r_wdata;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [31:0]       r_resp_rdata;
   logic              r_resp_error;
   logic              w_bad;
   logic              w_word_store;

   // Illegal size, or a half/word whose address is not naturally aligned.
   function automatic logic f_bad(input logic [1:0] size, input logic [1:0] a);
      logic bad;
      case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = a[0];
         2'b10:   bad = (a != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] a, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = 8'(word >> {a, 3'b000});
      h = 16'(word >> {a[1], 4'b0000});
      case (size)
         2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wdata,
                                           input logic [1:0] size, input logic [1:0] a);
      logic [31:0] mask;
      logic [31:0] data;
      case (size)
         2'b00: begin
            mask = 32'h0000_00FF << {a, 3'b000};
            data = {24'd0, wdata[7:0]} << {a, 3'b000};
         end
         2'b01: begin
            mask = 32'h0000_FFFF << {a[1], 4'b0000};
            data = {16'd0, wdata[15:0]} << {a[1], 4'b0000};
         end
         default: begin
            mask = 32'hFFFF_FFFF;
            data = wdata;
         end
      endcase
      return (old & ~mask) | (data & mask);
   endfunction

   assign w_bad        = f_bad(i_req_size, i_req_addr[1:0]);
   assign w_word_store = i_req_write && (i_req_size == 2'b10);

   // Request sequencing; response data and memory address/data are all registered here.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_write      <= 1'b0;
         r_size       <= 2'b00;
         r_unsigned   <= 1'b0;
         r_addr_lo    <= 2'b00;
         r_wdata      <= 32'd0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= 32'd0;
         r_resp_rdata <= 32'd0;
         r_resp_error <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_write     <= i_req_write;
                  r_size      <= i_req_size;
                  r_unsigned  <= i_req_unsigned;
                  r_addr_lo   <= i_req_addr[1:0];
                  r_wdata     <= i_req_wdata;
                  r_mem_addr  <= {i_req_addr[ADDR_W-1:2], 2'b00};
                  r_mem_wdata <= i_req_wdata;
                  if (w_bad) begin
                     r_resp_rdata <= 32'd0;
                     r_resp_error <= 1'b1;
                     r_state      <= S_RESP;
                  end else if (w_word_store) begin
                     r_state <= S_WR;
                  end else begin
                     r_state <= S_RD;
                  end
               end
            end
            S_RD: begin
               if (r_write) begin
                  r_mem_wdata <= f_merge(i_mem_rdata, r_wdata, r_size, r_addr_lo);
                  r_state     <= S_WR;
               end else begin
                  r_resp_rdata <= f_extract(i_mem_rdata, r_size, r_addr_lo, r_unsigned);
                  r_resp_error <= 1'b0;
                  r_state      <= S_RESP;
               end
            end
            S_WR: begin
               r_resp_rdata <= 32'd0;
               r_resp_error <= 1'b0;
               r_state      <= S_RESP;
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Strobes are gated by reset so a WR cut short by reset never writes memory.
   assign o_req_ready  = (r_state == S_IDLE) && !i_reset;
   assign o_mem_read   = (r_state == S_RD)   && !i_reset;
   assign o_mem_write  = (r_state == S_WR)   && !i_reset;
   assign o_resp_valid = (r_state == S_RESP) && !i_reset;
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_error = r_resp_error;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, directed cases, random traffic.
module tb_load_store_unit;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid, resp_error;
   logic [31:0] resp_rdata;
   logic [7:0]  mem_addr;
   logic        mem_read, mem_write;
   logic [31:0] mem_wdata, mem_rdata;

   logic [31:0] dmem [64];
   logic [7:0]  rbytes [256];
   logic        pl_en;
   logic [5:0]  pl_idx;
   logic [31:0] pl_word;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(8)) dut (
      .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_write(req_write), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_resp_valid(resp_valid),
      .o_resp_rdata(resp_rdata), .o_resp_error(resp_error), .o_mem_addr(mem_addr),
      .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata)
   );

   // D-MEM environment: asynchronous read, write on rising edge
   assign mem_rdata = dmem[mem_addr[7:2]];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_write) dmem[mem_addr[7:2]] <= mem_wdata;
      else if (pl_en) dmem[pl_idx] <= pl_word;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit is_err(input logic [1:0] sz, input logic [7:0] a);
      return (sz == 2'd3) || ((int'(a) % nbytes(sz)) != 0);
   endfunction

   function automatic logic [31:0] model_load(input logic [7:0] a, input logic [1:0] sz, input logic uns);
      logic [31:0] v;
      int n;
      n = nbytes(sz);
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(rbytes[int'(a) + i]) << (8 * i));
      if (n < 4 && !uns && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   task automatic preload(input logic [7:0] a, input logic [31:0] w);
      pl_en = 1'b1; pl_idx = a[7:2]; pl_word = w;
      for (int i = 0; i < 4; i++) rbytes[{a[7:2], 2'b00} + i] = 8'(w >> (8 * i));
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge of cycle 1 after acceptance.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic uns, input logic [7:0] a,
                        input logic [31:0] wd, input bit track, input bit hold);
      exp_t e;
      int   t;
      t = 0;
      while (!req_ready && t < 50) begin @(negedge clk); t++; end
      chk("ready_wait", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      if (track) begin
         if (is_err(sz, a)) begin
            e.rdata = 32'd0; e.err = 1'b1; e.cyc = cyc + 1;
         end else if (wr) begin
            for (int i = 0; i < nbytes(sz); i++) rbytes[int'(a) + i] = 8'(wd >> (8 * i));
            e.rdata = 32'd0; e.err = 1'b0; e.cyc = cyc + ((sz == 2'd2) ? 2 : 3);
         end else begin
            e.rdata = model_load(a, sz, uns); e.err = 1'b0; e.cyc = cyc + 2;
         end
         sb.push_back(e);
      end
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || !req_ready) && t < 100) begin @(negedge clk); t++; end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: every response pops the oldest expectation
   always @(negedge clk) begin
      if (resp_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
            chk("resp_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] sz;
      logic [7:0] a;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 8'd0; req_wdata = 32'd0; pl_en = 1'b0; pl_idx = 6'd0; pl_word = 32'd0;
      @(negedge clk);
      for (int i = 0; i < 64; i++) preload(8'(i * 4), $urandom);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
      chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
      chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      reset = 1'b0;
      #1 chk("rst_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);

      // word store then word load
      issue(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 1'b1, 1'b0);
      chk("ws_mem_write", {31'd0, mem_write}, 32'd1);
      chk("ws_mem_addr", {24'd0, mem_addr}, 32'h10);
      chk("ws_mem_wdata", mem_wdata, 32'hDEADBEEF);
      issue(1'b0, 2'd2, 1'b0, 8'h10, 32'd0, 1'b1, 1'b0);
      drain();

      // byte store RMW, then signed and unsigned byte loads
      preload(8'h10, 32'h0000_0000);
      issue(1'b1, 2'd0, 1'b0, 8'h11, 32'h0000_00A5, 1'b1, 1'b0);
      chk("bs_mem_read", {30'd0, mem_read, mem_write}, 32'd2);
      @(negedge clk);
      chk("bs_mem_write", {30'd0, mem_read, mem_write}, 32'd1);
      chk("bs_mem_wdata", mem_wdata, 32'h0000_A500);
      issue(1'b0, 2'd0, 1'b0, 8'h11, 32'd0, 1'b1, 1'b0);
      issue(1'b0, 2'd0, 1'b1, 8'h11, 32'd0, 1'b1, 1'b0);
      drain();

      // half store RMW, then signed half load
      preload(8'h10, 32'h1122_3344);
      issue(1'b1, 2'd1, 1'b0, 8'h12, 32'h0000_8001, 1'b1, 1'b0);
      @(negedge clk);
      chk("hs_mem_wdata", mem_wdata, 32'h8001_3344);
      issue(1'b0, 2'd1, 1'b0, 8'h12, 32'd0, 1'b1, 1'b0);
      drain();

      // errors never reach memory
      issue(1'b0, 2'd2, 1'b0, 8'h13, 32'd0, 1'b1, 1'b0);
      chk("err1_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
      issue(1'b1, 2'd1, 1'b0, 8'h05, 32'h1234, 1'b1, 1'b0);
      chk("err2_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
      issue(1'b0, 2'd3, 1'b0, 8'h08, 32'd0, 1'b1, 1'b0);
      chk("err3_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
      drain();

      // reset during WR of a byte store: no write, no response
      preload(8'h20, 32'h1234_5678);
      issue(1'b1, 2'd0, 1'b0, 8'h21, 32'h0000_0099, 1'b0, 1'b0);
      @(negedge clk);
      chk("rw_in_wr", {31'd0, mem_write}, 32'd1);
      reset = 1'b1;
      #1 chk("rw_write_gated", {31'd0, mem_write}, 32'd0);
      @(negedge clk);
      chk("rw_outs_zero", {29'd0, resp_valid, mem_read, mem_write}, 32'd0);
      chk("rw_rdata_zero", resp_rdata, 32'd0);
      chk("rw_mem_addr_zero", {24'd0, mem_addr}, 32'd0);
      chk("rw_mem_wdata_zero", mem_wdata, 32'd0);
      reset = 1'b0;
      #1 chk("rw_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      issue(1'b0, 2'd2, 1'b0, 8'h20, 32'd0, 1'b1, 1'b0);
      drain();

      // back-to-back loads with req_valid held high
      for (int k = 0; k < 3; k++) begin
         issue(1'b0, 2'd2, 1'b0, 8'(8'h30 + 8'(4 * k)), 32'd0, 1'b1, 1'b1);
         chk("b2b_ready_rd", {31'd0, req_ready}, 32'd0);
         if (k == 2) req_valid = 1'b0;
         @(negedge clk);
         chk("b2b_ready_resp", {31'd0, req_ready}, 32'd0);
      end
      drain();

      // random traffic against the byte-array model
      for (int n = 0; n < 200; n++) begin
         sz = 2'($urandom_range(0, 3));
         a  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~8'(nbytes(sz) - 1);
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1, 1'b0);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
